// File: rtl/baud_rate_pkg.sv
// rtl/baud_rate_pkg.sv - shared types, constants and bit-timing helpers for the baud_rate receiver
package baud_rate_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic int calc_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

    function automatic int calc_half(input int clock_rate, input int baud_rate);
        return calc_bit(clock_rate, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/baud_rate_if.sv
// rtl/baud_rate_if.sv - serial input and received-byte output bundle for baud_rate
interface baud_rate_if;
    import baud_rate_pkg::*;

    logic                 rx;
    logic                 UART_RX_Ready_Out;
    logic [DATA_BITS-1:0] UART_RX_Data_Out;

    modport master (
        output rx,
        input  UART_RX_Ready_Out,
        input  UART_RX_Data_Out
    );

    modport slave (
        input  rx,
        output UART_RX_Ready_Out,
        output UART_RX_Data_Out
    );

endinterface

// File: rtl/baud_rate_rx_majority_filter.sv
// rtl/baud_rate_rx_majority_filter.sv - 3-tap majority vote on the raw RX pin
module rx_majority_filter (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic m_o
);

    logic [2:0] maj_q;

    // Presetting to all ones keeps the filtered line idle-high out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj_q <= 3'b111;
        end else begin
            maj_q <= {maj_q[1:0], rx_i};
        end
    end

    assign m_o = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);

endmodule

// File: rtl/baud_rate.sv
// rtl/baud_rate.sv - oversampling 8N1 UART receiver with one-cycle byte strobe
module baud_rate
    import baud_rate_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic          clk,
    input  logic          rst,
    baud_rate_if.slave    bus
);

    localparam int BIT    = calc_bit(CLOCK_RATE, BAUD_RATE);
    localparam int HALF   = calc_half(CLOCK_RATE, BAUD_RATE);
    localparam int CW     = $clog2(BIT) + 1;
    localparam int IDX_W  = $clog2(DATA_BITS);

    if (BIT < 4) begin : g_bit_check
        $error("baud_rate: CLOCK_RATE/BAUD_RATE must be at least 4");
    end

    logic                 m;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;

    rx_majority_filter u_filter (
        .clk  (clk),
        .rst  (rst),
        .rx_i (bus.rx),
        .m_o  (m)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
        end
    end

    // cnt restarts on every state change (and every data bit) so each compare is relative to that event
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!m) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!m) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CW'(BIT - 1)) begin
                    cnt_d     = '0;
                    shreg_d   = {m, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CW'(BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // A low stop bit is a framing error: the byte is silently dropped
                    if (m) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.UART_RX_Ready_Out = ready_q;
    assign bus.UART_RX_Data_Out  = data_q;

endmodule

// File: tb/tb_baud_rate.sv
// tb/tb_baud_rate.sv - self-checking bench for baud_rate at BIT=10, HALF=5
`timescale 1ns/1ps
module tb_baud_rate;
    import baud_rate_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    baud_rate_if bus ();

    baud_rate #(
        .CLOCK_RATE (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         bit_ns;
        int         gap_ns;
        logic [7:0] exp_out;
        int         kind;
    } vec_t;

    logic [7:0] exp_q[$];
    int         start_cyc;
    int         last_rdy_cyc;
    int         prev_rdy_cyc;
    logic       prev_ready;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.UART_RX_Ready_Out) begin
            prev_rdy_cyc = last_rdy_cyc;
            last_rdy_cyc = cyc;
            check("ready_width", int'(prev_ready), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                check("rx_data", int'(bus.UART_RX_Data_Out), int'(exp_q.pop_front()));
            end
        end
        prev_ready = bus.UART_RX_Ready_Out;
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bit_ns);
        start_cyc = cyc;
        if (stop_ok) exp_q.push_back(d);
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            #(bit_ns);
        end
        bus.rx = stop_ok;
        #(bit_ns);
        bus.rx = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        last_rdy_cyc = 0;
        prev_rdy_cyc = 0;
        prev_ready   = 1'b0;
        rst          = 1'b1;
        bus.rx       = 1'b1;

        // kind: 0 data only, 1 start-to-ready latency, 2 spacing from previous Ready
        vecs[0] = '{8'hA5, 1'b1, 100, 200, 8'hA5, 1};
        vecs[1] = '{8'h00, 1'b1, 100,   0, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 100, 200, 8'hFF, 2};
        vecs[3] = '{8'h3C, 1'b0, 100, 200, 8'hFF, 0};
        vecs[4] = '{8'h81, 1'b1, 100, 200, 8'h81, 0};
        vecs[5] = '{8'hC3, 1'b1, 104, 200, 8'hC3, 0};

        repeat (3) @(negedge clk);
        check("reset_ready", int'(bus.UART_RX_Ready_Out), 0);
        check("reset_data", int'(bus.UART_RX_Data_Out), 0);
        check("reset_state", int'(dut.state_q), int'(IDLE));
        rst = 1'b0;
        #100;

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].bit_ns);
            if (vecs[v].gap_ns > 0) begin
                #(vecs[v].gap_ns);
                drain();
                check($sformatf("data_hold_%0d", v), int'(bus.UART_RX_Data_Out), int'(vecs[v].exp_out));
                if (vecs[v].kind == 1) begin
                    checks++;
                    if (last_rdy_cyc - (start_cyc + 1) < 96 || last_rdy_cyc - (start_cyc + 1) > 98) begin
                        failures++;
                        $display("FAIL latency actual=%0d required=97+-1", last_rdy_cyc - (start_cyc + 1));
                    end
                end
                if (vecs[v].kind == 2) begin
                    check("b2b_spacing", last_rdy_cyc - prev_rdy_cyc, 100);
                end
            end
        end

        // One-cycle glitch, then a 3-cycle pulse that reaches START but fails mid-bit validation
        bus.rx = 1'b0;
        #10;
        bus.rx = 1'b1;
        #200;
        check("glitch1_state", int'(dut.state_q), int'(IDLE));
        check("glitch1_data", int'(bus.UART_RX_Data_Out), 8'hC3);
        bus.rx = 1'b0;
        #30;
        bus.rx = 1'b1;
        #200;
        check("glitch3_state", int'(dut.state_q), int'(IDLE));
        check("glitch3_data", int'(bus.UART_RX_Data_Out), 8'hC3);

        // Reset in the middle of data bit 4 of 0x55
        bus.rx = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h55 >> i) & 1'b1;
            #100;
        end
        bus.rx = 1'b1;
        #50;
        rst = 1'b1;
        #1;
        check("midreset_ready", int'(bus.UART_RX_Ready_Out), 0);
        check("midreset_data", int'(bus.UART_RX_Data_Out), 0);
        check("midreset_state", int'(dut.state_q), int'(IDLE));
        #19;
        rst = 1'b0;
        #200;
        send_frame(8'h12, 1'b1, 100);
        #200;
        drain();
        check("after_reset_data", int'(bus.UART_RX_Data_Out), 8'h12);
        check("final_state", int'(dut.state_q), int'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baud_rate.md
# baud_rate

Oversampling UART receiver. It recovers 8N1 bytes from an asynchronous serial line and presents each byte with a one-cycle valid strobe. It sits between the board RX pin and any byte-stream consumer, and contains its own bit-timing counter derived from `CLOCK_RATE` and `BAUD_RATE`.

## Interface
- `CLOCK_RATE`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in baud.
- Derived constants:
  - `BIT = CLOCK_RATE/BAUD_RATE`, integer division.
  - `HALF = BIT/2`.
  - `BIT >= 4` is required; elaboration fails otherwise.
- Counter width is `$clog2(BIT)+1`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high.
- `UART_RX_Ready_Out`  out  1  one-cycle strobe: a byte was received with a valid stop bit.
- `UART_RX_Data_Out`  out  8  last correctly received byte, held until the next valid byte.

## Operation
- **Input filter**
  - 3-bit shift register `maj_buf`, shifted in from `rx` every clock.
  - Filtered value `m` is the combinational majority of the 3 bits.
  - `rst` sets `maj_buf` to 3'b111, so `m` resets high.
- **Bit timer**
  - Counter `cnt` is cleared on every state transition and increments otherwise.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if `m==0` -> START.
  - START (validates the start bit at mid-bit): when `cnt==HALF-1`:
    - if `m==0` -> DATA, with `bit_idx=0`;
    - otherwise -> IDLE (glitch, no output).
  - DATA: when `cnt==BIT-1`:
    - shift `m` into the MSB of `shreg` (LSB-first line order);
    - increment `bit_idx`, clear `cnt`;
    - after the 8th sample -> STOP.
  - STOP: when `cnt==BIT-1`:
    - if `m==1`: `UART_RX_Data_Out <= shreg` and `UART_RX_Ready_Out <= 1` for exactly one cycle;
    - otherwise it is a framing error: the byte is discarded and the output is unchanged;
    - in both cases -> IDLE.
- **Reset values:** state IDLE, `cnt=0`, `bit_idx=0`, `shreg=0`, `UART_RX_Data_Out=0`, `UART_RX_Ready_Out=0`.

## Timing
- Filter latency: a level change on `rx` that is stable for at least 2 clocks appears on `m` after 2 rising edges.
- Pulses of 1 clock on `rx` are rejected entirely.
- Let e0 be the edge at which IDLE sees `m==0`:
  - start bit validated at e0+HALF;
  - data bit k sampled at e0+HALF+(k+1)·BIT, for k=0..7;
  - stop bit sampled at e0+HALF+9·BIT.
- Ready is high during the single cycle following e0+HALF+9·BIT.
- Data is updated on the same edge as Ready and is valid while Ready is high.
- Back-to-back frames:
  - the FSM is in IDLE one cycle after the stop sample;
  - a start bit whose falling edge arrives during the second half of the stop bit is detected without loss.
- `rx` held low (break): produces a framing error, returns to IDLE, then immediately re-enters START. There is no lock-up.
- `rst` asserted mid-frame:
  - all state returns to reset values asynchronously;
  - no Ready is generated for the partial frame;
  - after release, reception starts at the next falling edge of `m`.
- Baud mismatch: up to ±4% total is tolerated, given centre sampling.

## Structure
- Package `baud_rate_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP);
  - function computing BIT/HALF from the two rates;
  - constant `DATA_BITS = 8`.
- One sub-module: `rx_majority_filter` (3-tap shift plus majority; reset preset 3'b111).
- The top level holds the counter, the FSM, the shift register and the output registers.

## Test plan
All scenarios use CLOCK_RATE=1_000_000 and BAUD_RATE=100_000, giving BIT=10 and HALF=5.
- Send 0xA5 at 10 clocks/bit -> one Ready pulse of exactly 1 cycle, `Data_Out=0xA5`, arriving 2+5+90 (±1) clocks after the start edge.
- Send 0x00, then 0xFF, back-to-back with a single stop bit -> two Ready pulses 100 clocks apart, data 0x00 then 0xFF.
- Send 0x3C with the stop bit forced low -> no Ready, `Data_Out` keeps the previous value 0xFF, next frame 0x81 received correctly.
- Single-cycle low glitch on idle `rx`, and a 3-cycle low pulse -> no Ready, FSM back in IDLE, `Data_Out` unchanged.
- Assert `rst` during data bit 4 of frame 0x55 -> Ready and Data immediately 0, no pulse; next frame 0x12 received correctly.
- Line rate 4% slow (BIT effectively 10.4) sending 0xC3 -> received 0xC3.
